flash_read_arbiter: RTL and testbench
=====================================

# flash_read_arbiter

Shares the single read port of the simulation flash model (one-cycle-latency, 64-bit read at a 32-bit byte address) between `NUM_REQ` independent requesters, e.g. the SPI-flash boot path and the debug/loader path. It runs a round-robin arbiter with one read outstanding, sequences the flash enable/address, captures the returned doubleword and holds it until the owning requester accepts it. It sits between the requesters' valid/ready channels and the flash model's `r_en`/`r_addr`/`r_data` pins.

## Interface
- `NUM_REQ`, default 2: number of requesters; legal range 2..8.
- `FLASH_SIZE`, default 4194304: flash capacity in bytes.
- `clock` in 1: sole clock.
- `reset` in 1: asynchronous, active-high reset.
- `req_valid` in NUM_REQ: per-requester read request.
- `req_ready` out NUM_REQ: one-hot request accept.
- `req_addr` in NUM_REQ*32: per-requester byte address; slice i is bits [32i+31:32i].
- `resp_valid` out NUM_REQ: one-hot; marks the response owner.
- `resp_ready` in NUM_REQ: per-requester response accept.
- `resp_data` out 64: shared response data, valid where `resp_valid[i]`.
- `resp_err` out 1: out-of-range flag, valid with `resp_valid`.
- `flash_r_en` out 1: flash read enable.
- `flash_r_addr` out 32: flash read address.
- `flash_r_data` in 64: flash data, valid the cycle after `flash_r_en`.

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, RESP. State resets to IDLE.
- **IDLE**
  - If any `req_valid` is high, the round-robin winner `g` gets `req_ready[g]=1` for one cycle.
  - `req_addr[g]` and `g` are latched, and the round-robin pointer is set to `g`.
  - If the address is in range, go to ISSUE; otherwise go to RESP with error set (macro on).
- **ISSUE**: `flash_r_en=1` and `flash_r_addr`=latched address for exactly one cycle. Next state is CAPTURE.
- **CAPTURE**: register `flash_r_data` into the response buffer and clear the error. Next state is RESP.
- **RESP**: `resp_valid[g]=1`, with `resp_data`/`resp_err` held stable. When `resp_ready[g]` is high, return to IDLE.
- `resp_ready` from non-owners is ignored.
- **Round-robin**
  - Search starts at pointer+1 mod NUM_REQ, checking in increasing index order with wrap.
  - The pointer resets to NUM_REQ-1, so requester 0 has first priority after reset.
- `req_ready` is only ever asserted in IDLE. Requests arriving in other states wait; a requester must hold `req_valid` and `req_addr` stable until accepted.
- When no request is active, `flash_r_addr` holds its last value; it is a don't-care while `flash_r_en=0`.

## Timing
- All outputs are registered or decoded from state, with one exception: `req_ready` is combinational from `req_valid` in IDLE.
- Reset values: `req_ready=0`, `resp_valid=0`, `resp_data=0`, `resp_err=0`, `flash_r_en=0`, `flash_r_addr=0`.
- Normal read timeline:
  - Accept in cycle T.
  - `flash_r_en` in T+1.
  - Capture at the end of T+2.
  - `resp_valid` from T+3.
  - Minimum request-to-request spacing is 4 cycles.
- Error read: `resp_valid` from T+1, with no flash access.
- Response back-pressure: RESP holds indefinitely and the buffer contents do not change.
- Asserting `reset` in any state immediately clears the FSM, pointer and outputs. An in-flight read is dropped and no response is produced for it.

## Configuration
- `FLASH_ARB_RANGE_CHECK_EN` defined:
  - A request with `addr + 7 >= FLASH_SIZE`, computed in 33-bit arithmetic so it cannot wrap, is not issued.
  - It is answered with `resp_data=0` and `resp_err=1`.
- Undefined:
  - No check; every request is issued.
  - `resp_err` is tied to 0.
  - Latency is always T+3.

## Structure
- Package `flash_arb_pkg` holds:
  - the state enum `flash_arb_state_e` (IDLE/ISSUE/CAPTURE/RESP);
  - the constants `FLASH_ARB_DATA_W=64`, `FLASH_ARB_ADDR_W=32` and `FLASH_ARB_DEFAULT_SIZE=4194304`.
- Sub-module `flash_rr_arbiter`:
  - combinational one-hot grant from the request vector and the pointer;
  - parameterised by `NUM_REQ`;
  - unit-tested separately.

## Test plan
- **Single read.** Requester 0 reads addr 0x0 with the flash preloaded `9b 02 10 00 93 92 f2 01`. Expect `flash_r_en` at T+1 with `flash_r_addr=0`, then `resp_valid=2'b01` at T+3 with `resp_data=64'h01f292930010029b` and `resp_err=0`.
- **Fairness.** Both requesters hold `req_valid` continuously, reading 0x0 and 0x8 with `resp_ready=1`. Grants alternate 0,1,0,1, each 4 cycles apart, and each `resp_data` matches its own address.
- **Back-pressure.** Hold `resp_ready=0` for 10 cycles in RESP while requester 1 requests. `resp_data` is stable, `req_ready[1]` stays 0, and requester 1 is granted in the cycle after the response completes.
- **Range error (macro on).** Request addr 0x3FFFF9. Expect no `flash_r_en`, `resp_valid` at T+1, `resp_err=1`, `resp_data=0`. Addr 0x3FFFF8 completes normally.
- **Reset mid-operation.** Assert `reset` during CAPTURE. All outputs are 0 immediately. After release, requester 0 wins over a simultaneous requester 1 request.

Source files
------------

// File: rtl/flash_arb_pkg.sv
// Shared types and constants for the flash read-port arbiter.
package flash_arb_pkg;

    localparam int unsigned FLASH_ARB_DATA_W       = 64;
    localparam int unsigned FLASH_ARB_ADDR_W       = 32;
    localparam int unsigned FLASH_ARB_DEFAULT_SIZE = 4194304;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } flash_arb_state_e;

endpackage

// File: rtl/flash_rr_arbiter.sv
// Combinational round-robin grant: search starts one past the pointer and wraps.
module flash_rr_arbiter #(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic        found;
    int unsigned idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            idx = (32'(ptr) + off) % NUM_REQ;
            if (!found && req[IDX_W'(idx)]) begin
                found                = 1'b1;
                grant[IDX_W'(idx)]   = 1'b1;
                grant_idx            = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/flash_read_arbiter.sv
// Shares the flash model read port among NUM_REQ requesters, one read outstanding.
// Optional out-of-range rejection enabled by defining FLASH_ARB_RANGE_CHECK_EN.
module flash_read_arbiter
    import flash_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned FLASH_SIZE = FLASH_ARB_DEFAULT_SIZE
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [NUM_REQ-1:0]                  req_valid,
    output logic [NUM_REQ-1:0]                  req_ready,
    input  logic [NUM_REQ*FLASH_ARB_ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]                  resp_valid,
    input  logic [NUM_REQ-1:0]                  resp_ready,
    output logic [FLASH_ARB_DATA_W-1:0]         resp_data,
    output logic                                resp_err,
    output logic                                flash_r_en,
    output logic [FLASH_ARB_ADDR_W-1:0]         flash_r_addr,
    input  logic [FLASH_ARB_DATA_W-1:0]         flash_r_data
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || FLASH_SIZE < 8) begin : g_bad_cfg
        $error("flash_read_arbiter: NUM_REQ must be 2..8 and FLASH_SIZE at least 8");
    end

    flash_arb_state_e              state_q, state_d;
    logic [IDX_W-1:0]              ptr_q;
    logic [NUM_REQ-1:0]            owner_q;
    logic [FLASH_ARB_ADDR_W-1:0]   addr_q;
    logic [FLASH_ARB_DATA_W-1:0]   data_q;
    logic [NUM_REQ-1:0]            grant;
    logic [IDX_W-1:0]              grant_idx;
    logic [FLASH_ARB_ADDR_W-1:0]   sel_addr;
    logic                          addr_err;
    logic                          accept;

    flash_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req       (req_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Address of the current round-robin winner.
    always_comb begin
        sel_addr = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (grant[i]) sel_addr = req_addr[i*FLASH_ARB_ADDR_W +: FLASH_ARB_ADDR_W];
        end
    end

`ifdef FLASH_ARB_RANGE_CHECK_EN
    // 33-bit sum so addresses near 4 GiB cannot wrap into range.
    assign addr_err = ({1'b0, sel_addr} + 33'd7) >= 33'(FLASH_SIZE);
`else
    assign addr_err = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!reset && (|req_valid)) begin
                    req_ready = grant;
                    accept    = 1'b1;
                    state_d   = addr_err ? RESP : ISSUE;
                end
            end
            ISSUE:   state_d = CAPTURE;
            CAPTURE: state_d = RESP;
            RESP: begin
                if (|(resp_ready & owner_q)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Grant bookkeeping and the response buffer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q   <= IDX_W'(NUM_REQ - 1);
            owner_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else if (accept) begin
            ptr_q   <= grant_idx;
            owner_q <= grant;
            if (addr_err) data_q <= '0;
            else          addr_q <= sel_addr;
        end else if (state_q == CAPTURE) begin
            data_q <= flash_r_data;
        end
    end

`ifdef FLASH_ARB_RANGE_CHECK_EN
    logic err_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)                       err_q <= 1'b0;
        else if (accept)                 err_q <= addr_err;
        else if (state_q == CAPTURE)     err_q <= 1'b0;
    end

    assign resp_err = err_q;
`else
    assign resp_err = 1'b0;
`endif

    assign flash_r_en   = (state_q == ISSUE);
    assign flash_r_addr = addr_q;
    assign resp_valid   = (state_q == RESP) ? owner_q : '0;
    assign resp_data    = data_q;

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Scoreboard bench for flash_read_arbiter with a one-cycle-latency flash model.
module tb_flash_read_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid, req_ready, resp_valid, resp_ready;
    logic [63:0] req_addr;
    logic [63:0] resp_data;
    logic [63:0] flash_r_data = 64'd0;
    logic        resp_err, flash_r_en;
    logic [31:0] flash_r_addr;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        logic [1:0]  owner;
        logic [63:0] data;
        logic        err;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    flash_read_arbiter #(.NUM_REQ(2), .FLASH_SIZE(4194304)) dut (
        .clock        (clk),
        .reset        (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_data    (resp_data),
        .resp_err     (resp_err),
        .flash_r_en   (flash_r_en),
        .flash_r_addr (flash_r_addr),
        .flash_r_data (flash_r_data)
    );

    function automatic logic [7:0] flash_byte(input logic [31:0] a);
        case (a)
            32'd0:   return 8'h9b;
            32'd1:   return 8'h02;
            32'd2:   return 8'h10;
            32'd3:   return 8'h00;
            32'd4:   return 8'h93;
            32'd5:   return 8'h92;
            32'd6:   return 8'hf2;
            32'd7:   return 8'h01;
            default: return 8'(a * 32'd37) ^ a[15:8] ^ a[23:16];
        endcase
    endfunction

    function automatic logic [63:0] flash_word(input logic [31:0] a);
        logic [63:0] w;
        for (int i = 0; i < 8; i++) w[8*i +: 8] = flash_byte(a + 32'(i));
        return w;
    endfunction

    // Flash model: data the cycle after the enable.
    always @(posedge clk) if (flash_r_en) flash_r_data <= flash_word(flash_r_addr);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Response monitor: every completed handshake is compared with the queue head.
    always @(negedge clk) begin
        if (!rst && ((resp_valid & resp_ready) != 2'b00)) begin
            exp_t e;
            if (exp_q.size() == 0) begin
                check("sb_unexpected", 64'(resp_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("sb_owner", 64'(resp_valid), 64'(e.owner));
                check("sb_data", resp_data, e.data);
                check("sb_err", 64'(resp_err), 64'(e.err));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic push_exp(input logic [1:0] owner, input logic [63:0] data, input logic err);
        exp_t e;
        e.owner = owner;
        e.data  = data;
        e.err   = err;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic wait_grant(input logic [1:0] oh, input string tag, output int at);
        int n = 0;
        sample();
        while (req_ready != oh && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_grant"}, 64'(req_ready), 64'(oh));
        at = cyc;
    endtask

    // Lone request from requester r; called at posedge+1 with the DUT idle.
    task automatic single_read(input int r, input logic [31:0] a, input logic err_exp,
                               input logic [63:0] exp_data, input string tag);
        logic [1:0] oh;
        oh = 2'b01 << r;
        push_exp(oh, exp_data, err_exp);
        req_addr[32*r +: 32] = a;
        req_valid = oh;
        sample();
        check({tag, "_ready"}, 64'(req_ready), 64'(oh));
        tick();
        req_valid = 2'b00;
        sample();
        if (err_exp) begin
            check({tag, "_no_flash"}, 64'(flash_r_en), 64'd0);
            check({tag, "_valid_t1"}, 64'(resp_valid), 64'(oh));
            check({tag, "_err"}, 64'(resp_err), 64'd1);
            check({tag, "_data0"}, resp_data, 64'd0);
        end else begin
            check({tag, "_en_t1"}, 64'(flash_r_en), 64'd1);
            check({tag, "_addr_t1"}, 64'(flash_r_addr), 64'(a));
            tick();
            sample();
            check({tag, "_en_t2"}, 64'(flash_r_en), 64'd0);
            check({tag, "_valid_t2"}, 64'(resp_valid), 64'd0);
            tick();
            sample();
            check({tag, "_valid_t3"}, 64'(resp_valid), 64'(oh));
            check({tag, "_data_t3"}, resp_data, exp_data);
            check({tag, "_err_t3"}, 64'(resp_err), 64'd0);
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        int c, prev;
        int n;
        rst        = 1'b1;
        req_valid  = 2'b00;
        req_addr   = '0;
        resp_ready = 2'b11;
        prev       = 0;
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_data", resp_data, 64'd0);
        check("rst_resp_err", 64'(resp_err), 64'd0);
        check("rst_flash_en", 64'(flash_r_en), 64'd0);
        check("rst_flash_addr", 64'(flash_r_addr), 64'd0);
        tick();
        tick();
        rst = 1'b0;

        single_read(0, 32'h0, 1'b0, 64'h01f292930010029b, "single");

        // Fairness: both requesters held valid continuously.
        do_reset();
        for (int k = 0; k < 4; k++)
            push_exp((k % 2) != 0 ? 2'b10 : 2'b01, flash_word((k % 2) != 0 ? 32'h8 : 32'h0), 1'b0);
        req_addr  = {32'h8, 32'h0};
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_grant((k % 2) != 0 ? 2'b10 : 2'b01, "fair", c);
            if (k > 0) check("fair_spacing", 64'(c - prev), 64'd4);
            prev = c;
        end
        tick();
        req_valid = 2'b00;
        drain("fair");

        // Back-pressure: owner 0 stalls while requester 1 waits.
        resp_ready = 2'b10;
        push_exp(2'b01, flash_word(32'h10), 1'b0);
        req_addr[31:0] = 32'h10;
        req_valid      = 2'b01;
        wait_grant(2'b01, "bp0", c);
        tick();
        req_valid = 2'b00;
        n = 0;
        sample();
        while (resp_valid != 2'b01 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp_resp", 64'(resp_valid), 64'(2'b01));
        tick();
        push_exp(2'b10, flash_word(32'h18), 1'b0);
        req_addr[63:32] = 32'h18;
        req_valid       = 2'b10;
        for (int i = 0; i < 10; i++) begin
            sample();
            check("bp_data_stable", resp_data, flash_word(32'h10));
            check("bp_hold_ready", 64'(req_ready), 64'd0);
            check("bp_hold_valid", 64'(resp_valid), 64'(2'b01));
            tick();
        end
        resp_ready = 2'b11;
        sample();
        check("bp_last_ready", 64'(req_ready), 64'd0);
        tick();
        sample();
        check("bp_grant1", 64'(req_ready), 64'(2'b10));
        tick();
        req_valid = 2'b00;
        drain("bp");

        // Range boundary.
`ifdef FLASH_ARB_RANGE_CHECK_EN
        single_read(0, 32'h3FFFF9, 1'b1, 64'd0, "range_err");
`else
        single_read(0, 32'h3FFFF9, 1'b0, flash_word(32'h3FFFF9), "range_nochk");
`endif
        single_read(1, 32'h3FFFF8, 1'b0, flash_word(32'h3FFFF8), "range_ok");
        drain("range");

        // Reset during CAPTURE: read dropped, requester 0 first afterwards.
        req_addr[31:0] = 32'h20;
        req_valid      = 2'b01;
        sample();
        check("rstmid_accept", 64'(req_ready), 64'(2'b01));
        tick();
        req_valid = 2'b00;
        tick();
        rst = 1'b1;
        #1;
        check("rstmid_resp_valid", 64'(resp_valid), 64'd0);
        check("rstmid_resp_data", resp_data, 64'd0);
        check("rstmid_resp_err", 64'(resp_err), 64'd0);
        check("rstmid_flash_en", 64'(flash_r_en), 64'd0);
        check("rstmid_flash_addr", 64'(flash_r_addr), 64'd0);
        check("rstmid_req_ready", 64'(req_ready), 64'd0);
        push_exp(2'b01, flash_word(32'h28), 1'b0);
        push_exp(2'b10, flash_word(32'h30), 1'b0);
        req_addr  = {32'h30, 32'h28};
        req_valid = 2'b11;
        tick();
        tick();
        rst = 1'b0;
        sample();
        check("rstmid_prio", 64'(req_ready), 64'(2'b01));
        tick();
        req_valid = 2'b10;
        wait_grant(2'b10, "rstmid_r1", c);
        tick();
        req_valid = 2'b00;
        drain("rstmid");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
